// File: rtl/ann_pkg.sv
// Shared ANN datapath constants and sequencer state encoding.
// The widths and term count are shared with the accumulator, so they live
// here rather than as per-module parameters.
package ann_pkg;
  localparam int N_TERMS = 4;   // terms per neuron, matches accumulator control
  localparam int IN_W    = 10;  // input activation width, unsigned
  localparam int W_W     = 10;  // weight width, unsigned
  localparam int B_W     = 8;   // bias width
  localparam int SUM_W   = 22;  // accumulator sum width
  localparam int OPND_W  = IN_W + W_W;  // full product width, never truncated
  localparam int K_W     = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  // Sequencer state encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/acc_operand_sequencer_if.sv
// Job and result channels between the layer scheduler and the sequencer.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
// master : scheduler side (offers jobs, consumes results)
// slave  : sequencer side (accepts jobs, offers results)
interface acc_operand_sequencer_if;
  import ann_pkg::*;

  logic                    job_valid;
  logic                    job_ready;
  logic [N_TERMS*IN_W-1:0] job_x;
  logic [N_TERMS*W_W-1:0]  job_w;
  logic [B_W-1:0]          job_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [SUM_W-1:0]        res_sum;

  modport master (
    output job_valid, job_x, job_w, job_b, res_ready,
    input  job_ready, res_valid, res_sum
  );

  modport slave (
    input  job_valid, job_x, job_w, job_b, res_ready,
    output job_ready, res_valid, res_sum
  );
endinterface

// File: rtl/term_product.sv
// Selects term sel_i from packed input/weight vectors and registers their
// full-width unsigned product. When en_i is low the register loads zero, so
// the accumulator sees a zero operand whenever no term is being issued.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   x_vec_i    packed inputs, term i at [i*IN_W +: IN_W]
//   w_vec_i    packed weights, term i at [i*W_W +: W_W]
//   sel_i      term index to multiply
//   en_i       load product (else load zero)
//   product_o  registered product
module term_product
  import ann_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_TERMS*IN_W-1:0] x_vec_i,
  input  logic [N_TERMS*W_W-1:0]  w_vec_i,
  input  logic [K_W-1:0]          sel_i,
  input  logic                    en_i,
  output logic [OPND_W-1:0]       product_o
);
  logic [IN_W-1:0]   x_sel;
  logic [W_W-1:0]    w_sel;
  logic [OPND_W-1:0] product_q;

  assign x_sel = x_vec_i[sel_i*IN_W +: IN_W];
  assign w_sel = w_vec_i[sel_i*W_W +: W_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      product_q <= '0;
    end else if (en_i) begin
      product_q <= OPND_W'(x_sel) * OPND_W'(w_sel);
    end else begin
      product_q <= '0;
    end
  end

  assign product_o = product_q;
endmodule

// File: rtl/acc_operand_sequencer.sv
// Feeds one neuron job at a time to the ANN accumulator: streams the N_TERMS
// products x[i]*w[i] one per cycle with acc_ready high, holds the bias on
// acc_b, waits SUM_LAT cycles with acc_ready low (which also clears the
// accumulator between jobs), captures acc_sum and offers it as a result.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          job/result channels (slave side)
//   acc_operand  registered product for the accumulator
//   acc_ready    high for exactly N_TERMS consecutive cycles per job
//   acc_b        bias, held for the whole job
//   acc_sum      accumulator result
//   busy         high in every state except IDLE
//   state_dbg_o  current FSM state
module acc_operand_sequencer
  import ann_pkg::*;
#(
  parameter int SUM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  acc_operand_sequencer_if.slave bus,
  output logic [OPND_W-1:0]      acc_operand,
  output logic                   acc_ready,
  output logic [B_W-1:0]         acc_b,
  input  logic [SUM_W-1:0]       acc_sum,
  output logic                   busy,
  output logic [1:0]             state_dbg_o
);
  localparam int              WT_W    = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(SUM_LAT - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(N_TERMS - 1);

  logic [1:0]              state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [WT_W-1:0]         wt_q, wt_d;
  logic [N_TERMS*IN_W-1:0] x_q, x_d;
  logic [N_TERMS*W_W-1:0]  w_q, w_d;
  logic                    acc_ready_q, acc_ready_d;
  logic [B_W-1:0]          acc_b_q, acc_b_d;
  logic                    res_valid_q, res_valid_d;
  logic [SUM_W-1:0]        res_sum_q, res_sum_d;
  logic                    job_ready_q;
  logic                    busy_q;
  logic                    job_accept;
  logic                    opnd_en;
  logic [K_W-1:0]          opnd_sel;
  logic [N_TERMS*IN_W-1:0] x_src;
  logic [N_TERMS*W_W-1:0]  w_src;

  assign job_accept = (state_q == IDLE) && bus.job_valid && job_ready_q;

  // The product register is one cycle ahead of the counter: on the accept
  // edge term 0 comes straight from the job bus, afterwards term k+1 comes
  // from the latched vectors while the counter still reads k.
  assign x_src    = (state_q == IDLE) ? bus.job_x : x_q;
  assign w_src    = (state_q == IDLE) ? bus.job_w : w_q;
  assign opnd_sel = (state_q == IDLE) ? '0 : k_q + K_W'(1);

  term_product u_term_product (
    .clk       (clk),
    .rst       (rst),
    .x_vec_i   (x_src),
    .w_vec_i   (w_src),
    .sel_i     (opnd_sel),
    .en_i      (opnd_en),
    .product_o (acc_operand)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wt_d        = wt_q;
    x_d         = x_q;
    w_d         = w_q;
    acc_ready_d = acc_ready_q;
    acc_b_d     = acc_b_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    opnd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_accept) begin
          x_d         = bus.job_x;
          w_d         = bus.job_w;
          acc_b_d     = bus.job_b;
          acc_ready_d = 1'b1;
          k_d         = '0;
          opnd_en     = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          acc_ready_d = 1'b0;
          k_d         = '0;
          wt_d        = '0;
          state_d     = WAIT;
        end else begin
          k_d     = k_q + K_W'(1);
          opnd_en = 1'b1;
        end
      end
      WAIT: begin
        if (wt_q == WT_LAST) begin
          res_sum_d   = acc_sum;
          res_valid_d = 1'b1;
          wt_d        = '0;
          state_d     = DONE;
        end else begin
          wt_d = wt_q + WT_W'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wt_q        <= '0;
      x_q         <= '0;
      w_q         <= '0;
      acc_ready_q <= 1'b0;
      acc_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wt_q        <= wt_d;
      x_q         <= x_d;
      w_q         <= w_d;
      acc_ready_q <= acc_ready_d;
      acc_b_q     <= acc_b_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      job_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.job_ready = job_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign acc_ready     = acc_ready_q;
  assign acc_b         = acc_b_q;
  assign busy          = busy_q;
  assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_acc_operand_sequencer.sv
// Bench for acc_operand_sequencer: two instances (SUM_LAT=1 and SUM_LAT=3),
// each with a behavioural accumulator that restarts from the bias whenever
// acc_ready rises and adds one operand per acc_ready cycle.
`timescale 1ns/1ps
module tb_acc_operand_sequencer;
  import ann_pkg::*;

  localparam int SUM_LAT_A = 1;
  localparam int SUM_LAT_B = 3;

  typedef logic [N_TERMS*IN_W-1:0] xv_t;
  typedef logic [N_TERMS*W_W-1:0]  wv_t;
  typedef logic [B_W-1:0]          b_t;
  typedef logic [SUM_W-1:0]        sum_t;
  typedef logic [OPND_W-1:0]       opnd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  acc_operand_sequencer_if bus ();
  acc_operand_sequencer_if bus3 ();

  opnd_t      acc_operand, acc_operand3;
  logic       acc_ready, acc_ready3;
  b_t         acc_b, acc_b3;
  sum_t       acc_sum = '0;
  sum_t       acc_sum3 = '0;
  logic       busy, busy3;
  logic [1:0] state_dbg, state_dbg3;

  acc_operand_sequencer #(.SUM_LAT(SUM_LAT_A)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .acc_operand(acc_operand), .acc_ready(acc_ready), .acc_b(acc_b),
    .acc_sum(acc_sum), .busy(busy), .state_dbg_o(state_dbg)
  );

  acc_operand_sequencer #(.SUM_LAT(SUM_LAT_B)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .acc_operand(acc_operand3), .acc_ready(acc_ready3), .acc_b(acc_b3),
    .acc_sum(acc_sum3), .busy(busy3), .state_dbg_o(state_dbg3)
  );

  // ---------------- accumulator models ----------------
  logic acc_first = 1'b1;
  logic acc_first3 = 1'b1;
  always @(posedge clk) begin
    if (acc_ready) acc_sum <= (acc_first ? sum_t'(acc_b) : acc_sum) + sum_t'(acc_operand);
    acc_first <= !acc_ready;
    if (acc_ready3) acc_sum3 <= (acc_first3 ? sum_t'(acc_b3) : acc_sum3) + sum_t'(acc_operand3);
    acc_first3 <= !acc_ready3;
  end

  // ---------------- scoreboard ----------------
  logic [OPND_W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.job_valid = 1'b0; bus.job_x = '0; bus.job_w = '0; bus.job_b = '0; bus.res_ready = 1'b0;
    bus3.job_valid = 1'b0; bus3.job_x = '0; bus3.job_w = '0; bus3.job_b = '0; bus3.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.job_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_job_ready: got %b expected 1", bus.job_ready); end
    tests_run++; if (acc_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_acc_ready: got %b expected 0", acc_ready); end
    tests_run++; if (acc_operand !== '0) begin tests_failed++; $display("FAIL reset_acc_operand: got %0d expected 0", acc_operand); end
    tests_run++; if (acc_b !== '0) begin tests_failed++; $display("FAIL reset_acc_b: got %0d expected 0", acc_b); end
    tests_run++; if (bus.res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    tests_run++; if (bus.res_sum !== '0) begin tests_failed++; $display("FAIL reset_res_sum: got %0d expected 0", bus.res_sum); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    tests_run++; if (bus3.job_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_job_ready_lat3: got %b expected 1", bus3.job_ready); end
    rst = 1'b0;
  endtask

  // Runs one job on the SUM_LAT_A instance. Starts and ends on a negedge;
  // it returns in the IDLE cycle that follows result completion.
  // hold: cycles to keep res_ready low after res_valid is seen.
  // keep_valid: leave job_valid high (with junk payload) while the job runs.
  task automatic do_job(input xv_t x, input wv_t w, input b_t b, input int hold,
                        input bit keep_valid, output sum_t got_sum);
    sum_t  exp_sum;
    opnd_t p;
    opnd_t e;
    int    edges;
    int    waitn;
    exp_sum = sum_t'(b);
    for (int i = 0; i < N_TERMS; i++) begin
      p = opnd_t'(x[i*IN_W +: IN_W]) * opnd_t'(w[i*W_W +: W_W]);
      exp_q.push_back(p);
      exp_sum = exp_sum + sum_t'(p);
    end
    bus.job_x = x; bus.job_w = w; bus.job_b = b; bus.job_valid = 1'b1;
    bus.res_ready = (hold == 0);
    waitn = 0;
    while (bus.job_ready !== 1'b1 && waitn < 50) begin @(negedge clk); waitn++; end
    tests_run++; if (waitn >= 50) begin tests_failed++; $display("FAIL handshake_timeout: waited %0d cycles, limit 50", waitn); end
    @(posedge clk);  // handshake edge
    @(negedge clk);
    bus.job_valid = keep_valid;
    bus.job_x = xv_t'({$urandom, $urandom});
    bus.job_w = wv_t'({$urandom, $urandom});
    bus.job_b = b_t'($urandom);
    edges = 0;
    for (int i = 0; i < N_TERMS; i++) begin
      if (i > 0) begin @(negedge clk); edges++; end
      e = exp_q.pop_front();
      tests_run++; if (acc_ready !== 1'b1) begin tests_failed++; $display("FAIL issue_acc_ready[%0d]: got %b expected 1", i, acc_ready); end
      tests_run++; if (acc_operand !== e) begin tests_failed++; $display("FAIL issue_operand[%0d]: got %0d expected %0d", i, acc_operand, e); end
      tests_run++; if (acc_b !== b) begin tests_failed++; $display("FAIL issue_acc_b[%0d]: got %0d expected %0d", i, acc_b, b); end
      tests_run++; if (bus.job_ready !== 1'b0) begin tests_failed++; $display("FAIL issue_job_ready[%0d]: got %b expected 0", i, bus.job_ready); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL issue_busy[%0d]: got %b expected 1", i, busy); end
    end
    @(negedge clk); edges++;
    tests_run++; if (acc_ready !== 1'b0) begin tests_failed++; $display("FAIL gap_acc_ready: got %b expected 0", acc_ready); end
    tests_run++; if (acc_operand !== '0) begin tests_failed++; $display("FAIL gap_operand: got %0d expected 0", acc_operand); end
    tests_run++; if (bus.job_ready !== 1'b0) begin tests_failed++; $display("FAIL wait_job_ready: got %b expected 0", bus.job_ready); end
    while (bus.res_valid !== 1'b1 && edges < 40) begin @(negedge clk); edges++; end
    // Edges after the handshake edge; counting the handshake edge itself
    // this is N_TERMS+SUM_LAT+1.
    tests_run++; if (edges != N_TERMS + SUM_LAT_A) begin tests_failed++; $display("FAIL res_latency: got %0d edges expected %0d", edges, N_TERMS + SUM_LAT_A); end
    tests_run++; if (bus.res_sum !== exp_sum) begin tests_failed++; $display("FAIL res_sum: got %0d expected %0d", bus.res_sum, exp_sum); end
    tests_run++; if (bus.job_ready !== 1'b0) begin tests_failed++; $display("FAIL done_job_ready: got %b expected 0", bus.job_ready); end
    got_sum = bus.res_sum;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      tests_run++; if (bus.res_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_res_valid[%0d]: got %b expected 1", h, bus.res_valid); end
      tests_run++; if (bus.res_sum !== exp_sum) begin tests_failed++; $display("FAIL hold_res_sum[%0d]: got %0d expected %0d", h, bus.res_sum, exp_sum); end
      tests_run++; if (bus.job_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_job_ready[%0d]: got %b expected 0", h, bus.job_ready); end
      tests_run++; if (acc_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_acc_ready[%0d]: got %b expected 0", h, acc_ready); end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.res_valid !== 1'b0) begin tests_failed++; $display("FAIL release_res_valid: got %b expected 0", bus.res_valid); end
    tests_run++; if (bus.job_ready !== 1'b1) begin tests_failed++; $display("FAIL release_job_ready: got %b expected 1", bus.job_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    sum_t s;
    do_job({10'd4, 10'd3, 10'd2, 10'd1}, {10'd8, 10'd7, 10'd6, 10'd5}, 8'd3, 0, 1'b0, s);
    tests_run++; if (s !== sum_t'(73)) begin tests_failed++; $display("FAIL basic_sum: got %0d expected 73", s); end
  endtask

  task automatic test_max_values();
    sum_t s;
    do_job({N_TERMS{10'd1023}}, {N_TERMS{10'd1023}}, 8'd255, 0, 1'b0, s);
    tests_run++; if (s !== sum_t'(4186371)) begin tests_failed++; $display("FAIL max_sum: got %0d expected 4186371", s); end
  endtask

  task automatic test_back_to_back();
    sum_t s;
    bus.res_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      do_job(xv_t'({$urandom, $urandom}), wv_t'({$urandom, $urandom}), b_t'($urandom), 0, 1'b1, s);
    end
    bus.job_valid = 1'b0;
  endtask

  task automatic test_res_hold();
    sum_t s;
    do_job(xv_t'({$urandom, $urandom}), wv_t'({$urandom, $urandom}), b_t'($urandom), 10, 1'b0, s);
  endtask

  task automatic test_reset_mid();
    sum_t s;
    int   seen;
    bus.job_x = xv_t'({$urandom, $urandom}); bus.job_w = wv_t'({$urandom, $urandom});
    bus.job_b = b_t'($urandom); bus.job_valid = 1'b1; bus.res_ready = 1'b1;
    @(posedge clk);  // in IDLE, so this is the handshake edge
    @(negedge clk);  // ISSUE cycle 1
    bus.job_valid = 1'b0;
    @(negedge clk);  // ISSUE cycle 2
    @(negedge clk);  // ISSUE cycle 3
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (acc_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_acc_ready: got %b expected 0", acc_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tests_run++; if (bus.res_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_res_valid: got %b expected 0", bus.res_valid); end
    tests_run++; if (bus.job_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_job_ready: got %b expected 1", bus.job_ready); end
    tests_run++; if (acc_operand !== '0) begin tests_failed++; $display("FAIL rstmid_operand: got %0d expected 0", acc_operand); end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1 || acc_ready === 1'b1) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", seen); end
    do_job(xv_t'({$urandom, $urandom}), wv_t'({$urandom, $urandom}), b_t'($urandom), 0, 1'b0, s);
  endtask

  task automatic test_random();
    sum_t s;
    for (int j = 0; j < 8; j++) begin
      do_job(xv_t'({$urandom, $urandom}), wv_t'({$urandom, $urandom}), b_t'($urandom),
             int'($urandom_range(0, 3)), 1'b0, s);
    end
  endtask

  task automatic test_sum_lat3();
    xv_t  x;
    wv_t  w;
    b_t   b;
    sum_t exp_sum;
    int   edges;
    x = xv_t'({$urandom, $urandom}); w = wv_t'({$urandom, $urandom}); b = b_t'($urandom);
    exp_sum = sum_t'(b);
    for (int i = 0; i < N_TERMS; i++)
      exp_sum = exp_sum + sum_t'(opnd_t'(x[i*IN_W +: IN_W]) * opnd_t'(w[i*W_W +: W_W]));
    bus3.job_x = x; bus3.job_w = w; bus3.job_b = b; bus3.job_valid = 1'b1; bus3.res_ready = 1'b1;
    tests_run++; if (bus3.job_ready !== 1'b1) begin tests_failed++; $display("FAIL lat3_idle_ready: got %b expected 1", bus3.job_ready); end
    @(posedge clk);  // handshake edge
    @(negedge clk);
    bus3.job_valid = 1'b0;
    edges = 0;
    while (bus3.res_valid !== 1'b1 && edges < 40) begin @(negedge clk); edges++; end
    // 7 edges after the handshake edge = 8 edges counting it.
    tests_run++; if (edges != N_TERMS + SUM_LAT_B) begin tests_failed++; $display("FAIL lat3_latency: got %0d edges expected %0d", edges, N_TERMS + SUM_LAT_B); end
    tests_run++; if (bus3.res_sum !== exp_sum) begin tests_failed++; $display("FAIL lat3_sum: got %0d expected %0d", bus3.res_sum, exp_sum); end
    @(negedge clk);
    tests_run++; if (bus3.res_valid !== 1'b0) begin tests_failed++; $display("FAIL lat3_release: got %b expected 0", bus3.res_valid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_max_values();
    test_back_to_back();
    test_res_hold();
    test_reset_mid();
    test_random();
    test_sum_lat3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
